// File: rtl/set_assoc_cache.sv
// set_assoc_cache: N-way set-associative write-through cache with a registered
// miss-refill FSM, round-robin replacement, per-set flush and saturating counters.

module set_assoc_cache_way #(
  parameter int INDEX_WIDTH = 4,
  parameter int TAG_WIDTH   = 26,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  input  logic [INDEX_WIDTH-1:0] idx,
  input  logic [TAG_WIDTH-1:0]   tag,
  input  logic                   fill_en,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wdata,
  input  logic                   clr_en,
  input  logic [INDEX_WIDTH-1:0] clr_idx,
  output logic                   vld,
  output logic                   hit,
  output logic [DATA_WIDTH-1:0]  rdata
);
  localparam int SETS = 1 << INDEX_WIDTH;

  logic [SETS-1:0]       vld_q;
  logic [TAG_WIDTH-1:0]  tag_q  [SETS];
  logic [DATA_WIDTH-1:0] data_q [SETS];

  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N)      vld_q <= '0;
    else if (clr_en)  vld_q[clr_idx] <= 1'b0;
    else if (fill_en) vld_q[idx] <= 1'b1;

  // Tag/data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge iCLK) begin
    if (fill_en)          tag_q[idx]  <= tag;
    if (fill_en || wr_en) data_q[idx] <= wdata;
  end

  assign vld   = vld_q[idx];
  assign hit   = vld_q[idx] && (tag_q[idx] == tag);
  assign rdata = data_q[idx];
endmodule

module set_assoc_cache #(
  parameter int INDEX_WIDTH = 4,
  parameter int WAYS        = 2,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                  iCLK,
  input  logic                  iRST_N,
  input  logic                  iReqValid,
  output logic                  oReqReady,
  input  logic                  iReqWe,
  input  logic [ADDR_WIDTH-1:0] iReqAddr,
  input  logic [DATA_WIDTH-1:0] iReqWData,
  output logic                  oRespValid,
  output logic [DATA_WIDTH-1:0] oRespData,
  output logic                  oMemReqValid,
  input  logic                  iMemReqReady,
  output logic                  oMemWe,
  output logic [ADDR_WIDTH-1:0] oMemAddr,
  output logic [DATA_WIDTH-1:0] oMemWData,
  input  logic                  iMemRespValid,
  input  logic [DATA_WIDTH-1:0] iMemRData,
  input  logic                  iFlush,
  output logic                  oFlushDone,
  output logic [31:0]           oHitCount,
  output logic [31:0]           oMissCount
);
  localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - 2;
  localparam int SETS      = 1 << INDEX_WIDTH;
  localparam int PTR_W     = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int WORD_W    = ADDR_WIDTH - 2;

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP, FLUSH} state_t;

  state_t                 state;
  logic [WORD_W-1:0]      req_word;
  logic                   req_we;
  logic [DATA_WIDTH-1:0]  req_wdata;
  logic                   flush_pending;
  logic [INDEX_WIDTH-1:0] flush_idx;
  logic [PTR_W-1:0]       vptr [SETS];
  logic [31:0]            hit_cnt, miss_cnt;

  logic                   resp_valid, mem_req_valid, mem_we, flush_done;
  logic [DATA_WIDTH-1:0]  resp_data, mem_wdata;
  logic [ADDR_WIDTH-1:0]  mem_addr;

  logic [INDEX_WIDTH-1:0] cur_idx;
  logic [TAG_WIDTH-1:0]   cur_tag;
  logic [WAYS-1:0]        way_vld, way_hit, fill_sel;
  logic [WAYS-1:0][DATA_WIDTH-1:0] way_rdata;
  logic                   any_hit, all_vld, fill_en, wr_hit, clr_en;
  logic [DATA_WIDTH-1:0]  hit_data, way_wdata;
  logic [PTR_W-1:0]       vic_way;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^iReqAddr[1:0];

  assign cur_idx   = req_word[INDEX_WIDTH-1:0];
  assign cur_tag   = req_word[WORD_W-1:INDEX_WIDTH];
  assign fill_en   = (state == MEM_WAIT) && iMemRespValid;
  assign wr_hit    = (state == LOOKUP) && req_we && any_hit;
  assign clr_en    = (state == FLUSH);
  assign way_wdata = fill_en ? iMemRData : req_wdata;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    set_assoc_cache_way #(
      .INDEX_WIDTH(INDEX_WIDTH), .TAG_WIDTH(TAG_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) u_way (
      .iCLK    (iCLK),
      .iRST_N  (iRST_N),
      .idx     (cur_idx),
      .tag     (cur_tag),
      .fill_en (fill_en && fill_sel[w]),
      .wr_en   (wr_hit && way_hit[w]),
      .wdata   (way_wdata),
      .clr_en  (clr_en),
      .clr_idx (flush_idx),
      .vld     (way_vld[w]),
      .hit     (way_hit[w]),
      .rdata   (way_rdata[w])
    );
  end

  // Victim: lowest invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    any_hit  = 1'b0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++)
      if (way_hit[w]) begin
        any_hit  = 1'b1;
        hit_data = way_rdata[w];
      end
    all_vld = &way_vld;
    vic_way = vptr[cur_idx];
    if (!all_vld)
      for (int w = WAYS - 1; w >= 0; w--)
        if (!way_vld[w]) vic_way = PTR_W'(w);
    fill_sel = '0;
    for (int w = 0; w < WAYS; w++)
      fill_sel[w] = (vic_way == PTR_W'(w));
  end

  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      for (int s = 0; s < SETS; s++) vptr[s] <= '0;
    end else if (clr_en) begin
      vptr[flush_idx] <= '0;
    end else if (fill_en && all_vld) begin
      vptr[cur_idx] <= (vptr[cur_idx] == PTR_W'(WAYS - 1)) ? '0 : vptr[cur_idx] + 1'b1;
    end

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (&c) ? c : c + 32'd1;
  endfunction

  assign oReqReady = iRST_N && (state == IDLE) && !flush_pending && !iFlush;

  always_ff @(posedge iCLK or negedge iRST_N)
    if (!iRST_N) begin
      state         <= IDLE;
      req_word      <= '0;
      req_we        <= 1'b0;
      req_wdata     <= '0;
      flush_pending <= 1'b0;
      flush_idx     <= '0;
      hit_cnt       <= '0;
      miss_cnt      <= '0;
      resp_valid    <= 1'b0;
      resp_data     <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      flush_done    <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      flush_done <= 1'b0;
      if (iFlush) flush_pending <= 1'b1;
      case (state)
        IDLE:
          if (flush_pending) begin
            state         <= FLUSH;
            flush_idx     <= '0;
            flush_pending <= iFlush;
          end else if (iReqValid && oReqReady) begin
            req_word  <= iReqAddr[ADDR_WIDTH-1:2];
            req_we    <= iReqWe;
            req_wdata <= iReqWData;
            state     <= LOOKUP;
          end
        LOOKUP: begin
          if (any_hit) hit_cnt  <= sat_inc(hit_cnt);
          else         miss_cnt <= sat_inc(miss_cnt);
          if (!req_we && any_hit) begin
            resp_data  <= hit_data;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            mem_req_valid <= 1'b1;
            mem_we        <= req_we;
            mem_addr      <= {req_word, 2'b00};
            mem_wdata     <= req_we ? req_wdata : '0;
            state         <= MEM_REQ;
          end
        end
        MEM_REQ:
          if (iMemReqReady) begin
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            if (mem_we) begin
              resp_data  <= '0;
              resp_valid <= 1'b1;
              state      <= RESP;
            end else begin
              state <= MEM_WAIT;
            end
          end
        MEM_WAIT:
          if (iMemRespValid) begin
            resp_data  <= iMemRData;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        RESP: begin
          resp_data <= '0;
          state     <= IDLE;
        end
        FLUSH: begin
          flush_idx <= flush_idx + 1'b1;
          if (&flush_idx) state <= IDLE;
          else flush_done <= (flush_idx == INDEX_WIDTH'(SETS - 2));
        end
        default: state <= IDLE;
      endcase
    end

  assign oRespValid   = resp_valid;
  assign oRespData    = resp_data;
  assign oMemReqValid = mem_req_valid;
  assign oMemWe       = mem_we;
  assign oMemAddr     = mem_addr;
  assign oMemWData    = mem_wdata;
  assign oFlushDone   = flush_done;
  assign oHitCount    = hit_cnt;
  assign oMissCount   = miss_cnt;
endmodule

// File: tb/tb_set_assoc_cache.sv
// Randomized bench for set_assoc_cache: cache contents, replacement and counters are
// predicted by a line-level model; the bench also plays the memory.

module tb_set_assoc_cache;
  localparam int IW = 4, WAYS = 2, DW = 32, AW = 32, SETS = 1 << IW;

  logic          iCLK = 1'b0, iRST_N = 1'b0;
  logic          iReqValid = 1'b0, iReqWe = 1'b0, iMemReqReady = 1'b0, iMemRespValid = 1'b0, iFlush = 1'b0;
  logic [AW-1:0] iReqAddr = '0;
  logic [DW-1:0] iReqWData = '0, iMemRData = '0;
  logic          oReqReady, oRespValid, oMemReqValid, oMemWe, oFlushDone;
  logic [DW-1:0] oRespData, oMemWData;
  logic [AW-1:0] oMemAddr;
  logic [31:0]   oHitCount, oMissCount;

  set_assoc_cache #(.INDEX_WIDTH(IW), .WAYS(WAYS), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iReqValid(iReqValid), .oReqReady(oReqReady),
    .iReqWe(iReqWe), .iReqAddr(iReqAddr), .iReqWData(iReqWData),
    .oRespValid(oRespValid), .oRespData(oRespData),
    .oMemReqValid(oMemReqValid), .iMemReqReady(iMemReqReady), .oMemWe(oMemWe),
    .oMemAddr(oMemAddr), .oMemWData(oMemWData), .iMemRespValid(iMemRespValid),
    .iMemRData(iMemRData), .iFlush(iFlush), .oFlushDone(oFlushDone),
    .oHitCount(oHitCount), .oMissCount(oMissCount));

  always #5 iCLK = ~iCLK;

  int checks = 0, errors = 0;

  // Memory image and a line-level model of the cache contents.
  logic [31:0]        mem [logic [31:0]];
  bit                 m_vld  [SETS][WAYS];
  logic [AW-IW-3:0]   m_tag  [SETS][WAYS];
  logic [31:0]        m_data [SETS][WAYS];
  int                 m_ptr  [SETS];
  longint             m_hits = 0, m_miss = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    if (mem.exists(w)) return mem[w];
    return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] sat(input longint c);
    return (c > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : c[31:0];
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < SETS; s++) begin
      m_ptr[s] = 0;
      for (int w = 0; w < WAYS; w++) m_vld[s][w] = 1'b0;
    end
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!oReqReady && n < 100) begin @(posedge iCLK); #1; n++; end
    chk("ready_wait", 32'(oReqReady), 32'd1);
  endtask

  // One CPU transaction; the bench answers memory after rdy_dly stall cycles
  // (showing a stray iMemRespValid meanwhile) and rsp_dly wait cycles.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input int rdy_dly, input int rsp_dly, input int flush_at);
    int s, hw, v, lat, stall, rsp_cnt, exp_lat, bad;
    logic [AW-IW-3:0] t;
    logic exp_hit, mreq, mwe;
    logic [31:0] exp_rd, ma, mwd;
    s = int'(addr[IW+1:2]);
    t = addr[AW-1:IW+2];
    hw = -1;
    for (int w = 0; w < WAYS; w++) if (m_vld[s][w] && m_tag[s][w] == t) hw = w;
    exp_hit = (hw >= 0);
    if (exp_hit) m_hits++; else m_miss++;
    exp_rd = '0;
    if (we) begin
      mem[{addr[31:2], 2'b00}] = wd;
      if (exp_hit) m_data[s][hw] = wd;
    end else if (exp_hit) begin
      exp_rd = m_data[s][hw];
    end else begin
      exp_rd = mem_val(addr);
      v = -1;
      for (int w = 0; w < WAYS; w++) if (!m_vld[s][w] && v < 0) v = w;
      if (v < 0) begin v = m_ptr[s]; m_ptr[s] = (m_ptr[s] + 1) % WAYS; end
      m_vld[s][v] = 1'b1; m_tag[s][v] = t; m_data[s][v] = exp_rd;
    end
    exp_lat = (exp_hit && !we) ? 2 : (we ? 3 + rdy_dly : 4 + rdy_dly + rsp_dly);

    wait_ready();
    iReqValid = 1'b1; iReqWe = we; iReqAddr = addr; iReqWData = wd;
    @(posedge iCLK); #1;
    iReqValid = 1'b0; iReqWData = $urandom;
    lat = 1; stall = 0; rsp_cnt = -1; mreq = 1'b0; mwe = 1'b0; ma = '0; mwd = '0; bad = 0;
    while (!oRespValid && lat < 200) begin
      iMemReqReady = 1'b0; iMemRespValid = 1'b0; iFlush = (lat == flush_at);
      if (oMemReqValid) begin
        if (!mreq) begin mreq = 1'b1; ma = oMemAddr; mwe = oMemWe; mwd = oMemWData; end
        else if (oMemAddr !== ma || oMemWe !== mwe || oMemWData !== mwd) bad++;
        if (stall >= rdy_dly) begin
          iMemReqReady = 1'b1;
          if (!mwe) rsp_cnt = rsp_dly;
        end else begin
          stall++;
          iMemRespValid = 1'b1; iMemRData = 32'hBAD0_BAD0;
        end
      end else if (rsp_cnt == 0) begin
        iMemRespValid = 1'b1; iMemRData = mem_val(ma); rsp_cnt = -1;
      end else if (rsp_cnt > 0) begin
        rsp_cnt--;
      end
      @(posedge iCLK); #1; lat++;
    end
    iMemReqReady = 1'b0; iMemRespValid = 1'b0; iFlush = 1'b0;

    chk("resp_seen", 32'(oRespValid), 32'd1);
    chk("resp_data", oRespData, exp_rd);
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("mem_req_issued", 32'(mreq), 32'(we || !exp_hit));
    if (mreq) begin
      chk("mem_addr", ma, {addr[31:2], 2'b00});
      chk("mem_we", 32'(mwe), 32'(we));
      if (we) chk("mem_wdata", mwd, wd);
      chk("mem_req_stable", 32'(bad), 32'd0);
    end
    chk("hit_count", oHitCount, sat(m_hits));
    chk("miss_count", oMissCount, sat(m_miss));
  endtask

  // Follows a flush from the cycle its request was taken; the done pulse is
  // expected on sample exp_done and the cache ready one cycle later.
  task automatic flush_wait(input int exp_done);
    int n = 0, done_at = -1, done_cnt = 0, stray = 0;
    do begin
      @(posedge iCLK); #1;
      iFlush = 1'b0; iReqValid = 1'b0;
      n++;
      if (oFlushDone) begin done_cnt++; done_at = n; end
      if (oRespValid || oMemReqValid) stray++;
    end while (!oReqReady && n < 200);
    chk("flush_done_at", 32'(done_at), 32'(exp_done));
    chk("flush_done_pulses", 32'(done_cnt), 32'd1);
    chk("flush_ready_at", 32'(n), 32'(exp_done + 1));
    chk("flush_no_traffic", 32'(stray), 32'd0);
    model_flush();
  endtask

  task automatic flush_with_req(input logic [31:0] addr);
    wait_ready();
    iFlush = 1'b1; iReqValid = 1'b1; iReqWe = 1'b0; iReqAddr = addr;
    #1;
    chk("flush_beats_req", 32'(oReqReady), 32'd0);
    flush_wait(SETS + 1);
  endtask

  initial begin
    logic [31:0] a;
    model_flush();
    mem[32'h40] = 32'hDEAD_BEEF;
    #2;
    chk("rst_ctl", {28'd0, oRespValid, oMemReqValid, oMemWe, oFlushDone}, 32'd0);
    chk("rst_counts", oHitCount | oMissCount, 32'd0);
    chk("rst_data", oRespData | oMemWData | oMemAddr, 32'd0);
    repeat (3) @(negedge iCLK);
    iRST_N = 1'b1;
    #1;
    chk("ready_after_rst", 32'(oReqReady), 32'd1);
    @(posedge iCLK); #1;

    // Basic miss then hit, then set-0 replacement order.
    access(1'b0, 32'h40, 0, 0, 0, -1);
    access(1'b0, 32'h40, 0, 0, 0, -1);
    chk("dir_hits", oHitCount, 32'd1);
    chk("dir_misses", oMissCount, 32'd1);
    access(1'b0, 32'h80, 0, 1, 2, -1);
    access(1'b0, 32'hC0, 0, 0, 1, -1);
    access(1'b0, 32'h80, 0, 0, 0, -1);
    access(1'b0, 32'h40, 0, 0, 0, -1);
    access(1'b0, 32'h80, 0, 0, 0, -1);
    access(1'b1, 32'h80, 32'h55, 0, 0, -1);
    access(1'b0, 32'h80, 0, 0, 0, -1);
    access(1'b1, 32'h100, 32'h1234, 2, 0, -1);
    access(1'b0, 32'h100, 0, 0, 0, -1);

    // Stalled miss with a flush arriving mid-transaction.
    access(1'b0, 32'h344, 0, 5, 1, 3);
    flush_wait(SETS + 1);
    access(1'b0, 32'h80, 0, 0, 0, -1);
    access(1'b0, 32'h344, 0, 0, 0, -1);
    flush_with_req(32'h80);

    // Randomized traffic over a few tags in two sets to force evictions.
    for (int i = 0; i < 200; i++) begin
      a = 32'(($urandom_range(0, 5) << (IW + 2)) | ($urandom_range(0, 1) << 2) | $urandom_range(0, 3));
      access(($urandom_range(0, 3) == 0), a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), -1);
      if ($urandom_range(0, 29) == 0) flush_with_req(a);
    end

    // Reset while waiting on memory read data.
    access(1'b0, 32'h2000, 0, 0, 0, -1);
    wait_ready();
    iReqValid = 1'b1; iReqWe = 1'b0; iReqAddr = 32'h5A40;
    @(posedge iCLK); #1; iReqValid = 1'b0;
    @(posedge iCLK); #1;
    chk("pre_rst_memreq", 32'(oMemReqValid), 32'd1);
    iMemReqReady = 1'b1;
    @(posedge iCLK); #1; iMemReqReady = 1'b0;
    #2; iRST_N = 1'b0; #1;
    chk("midrst_ctl", {28'd0, oRespValid, oMemReqValid, oMemWe, oFlushDone}, 32'd0);
    chk("midrst_counts", oHitCount | oMissCount, 32'd0);
    chk("midrst_data", oRespData | oMemWData | oMemAddr, 32'd0);
    @(negedge iCLK); iRST_N = 1'b1; #1;
    chk("ready_after_midrst", 32'(oReqReady), 32'd1);
    model_flush(); m_hits = 0; m_miss = 0;
    access(1'b0, 32'h2000, 0, 0, 0, -1);

    // Miss counter saturation.
    wait_ready();
    force dut.miss_cnt = 32'hFFFF_FFFE;
    @(posedge iCLK); #1;
    release dut.miss_cnt;
    m_miss = 64'hFFFF_FFFE;
    chk("miss_preload", oMissCount, 32'hFFFF_FFFE);
    access(1'b0, 32'h10000, 0, 0, 0, -1);
    access(1'b0, 32'h20004, 0, 0, 0, -1);
    access(1'b1, 32'h30008, 32'h77, 0, 0, -1);
    chk("miss_saturated", oMissCount, 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/set_assoc_cache.md
# set_assoc_cache

Parametrised N-way set-associative read/write-through cache sitting between the CPU load/store port and main memory. It is the successor to the direct-mapped cache and adds three things: configurable associativity with round-robin replacement, a registered miss-refill FSM with valid/ready handshakes on both sides, and a sequenced full-cache flush. Saturating hit and miss counters support performance measurement.

## Interface
- INDEX_WIDTH, 4: set index bits; 2**INDEX_WIDTH sets.
- WAYS, 2: associativity; legal values 1, 2, 4.
- DATA_WIDTH, 32: word width; one word per line.
- ADDR_WIDTH, 32: byte address width.
- TAG_WIDTH is derived: ADDR_WIDTH-INDEX_WIDTH-2.
- Address split: offset = addr[1:0] (ignored); index = addr[INDEX_WIDTH+1:2]; tag = addr[ADDR_WIDTH-1:INDEX_WIDTH+2].

Ports:
- iCLK  in  1  clock, rising edge.
- iRST_N  in  1  asynchronous, active-low reset.
- iReqValid  in  1  CPU request valid.
- oReqReady  out  1  cache can accept a request.
- iReqWe  in  1  1 = write, 0 = read.
- iReqAddr  in  ADDR_WIDTH  request byte address.
- iReqWData  in  DATA_WIDTH  write data.
- oRespValid  out  1  one-cycle completion pulse.
- oRespData  out  DATA_WIDTH  read data; 0 for writes.
- oMemReqValid  out  1  memory request valid.
- iMemReqReady  in  1  memory accepts request.
- oMemWe  out  1  memory write.
- oMemAddr  out  ADDR_WIDTH  word-aligned memory address.
- oMemWData  out  DATA_WIDTH  memory write data.
- iMemRespValid  in  1  read data valid.
- iMemRData  in  DATA_WIDTH  memory read data.
- iFlush  in  1  flush request (pulse or level).
- oFlushDone  out  1  one-cycle pulse when the flush completes.
- oHitCount, oMissCount  out  32 each  saturating counters.

## Operation
- Storage is per set and per way: valid bit, tag, data. Each set also holds one victim pointer of clog2(WAYS) bits. All storage is flops.
- States: IDLE, LOOKUP, MEM_REQ, MEM_WAIT, RESP, FLUSH.
- oReqReady = (state==IDLE) && !flush_pending && !iFlush.
- IDLE: a request is accepted when iReqValid && oReqReady. On accept, latch addr, we and wdata, then go to LOOKUP.
- LOOKUP, all ways compared in parallel:
  - Read hit: latch the hit way's data, HitCount++, go to RESP.
  - Read miss: MissCount++, go to MEM_REQ with oMemWe=0.
  - Write hit: update the hit way's data, HitCount++, go to MEM_REQ with oMemWe=1.
  - Write miss: MissCount++, go to MEM_REQ with oMemWe=1. No allocation.
- MEM_REQ: hold oMemReqValid, oMemAddr = {addr[ADDR_WIDTH-1:2],2'b00}, oMemWData and oMemWe stable until iMemReqReady.
  - On handshake, a write goes to RESP and a read goes to MEM_WAIT.
- MEM_WAIT: on iMemRespValid, fill the line and latch iMemRData, then go to RESP.
- Victim selection on fill: lowest-numbered invalid way. If all ways are valid, use the way named by the victim pointer, then advance that pointer modulo WAYS. Fills into invalid ways leave the pointer unchanged.
- RESP: oRespValid=1 for one cycle with oRespData, then go to IDLE.
- Flush:
  - iFlush in any state sets flush_pending.
  - From IDLE with flush_pending, enter FLUSH.
  - FLUSH clears the valid bits and victim pointer of one set per cycle, starting at set 0 and ending at set 2**INDEX_WIDTH-1.
  - oFlushDone pulses on the last cycle of FLUSH, then the FSM returns to IDLE.
  - Counters are not cleared by a flush.
- A flush arriving mid-miss does not abort the transaction. It runs after RESP.
- Counters saturate at 32'hFFFF_FFFF.
- WAYS=1 degenerates to direct-mapped. The victim pointer is unused.

## Timing
- Reset (async assert, sync release) puts the block in IDLE, clears all valid bits, pointers and counters, and drives every output to 0 except oReqReady. oReqReady is 1 once iRST_N is high. Reset mid-transaction abandons the memory request; oMemReqValid drops immediately.
- Read hit: accepted at edge k, oRespValid high from edge k+2 to k+3. Minimum request-to-request spacing is 3 cycles.
- Read miss: oMemReqValid rises at edge k+2. Data appears one cycle after the iMemRespValid edge.
- Write: completion is one cycle after the iMemReqReady handshake.
- iFlush and iReqValid together in IDLE: flush wins and no request is accepted that cycle.
- Flush takes exactly 2**INDEX_WIDTH cycles in FLUSH, during which oReqReady=0.
- A fill and a lookup never overlap, so there is no read-during-write hazard.
- iMemRespValid outside MEM_WAIT is ignored.

## Test plan
- Reset, then read 0x40 with memory returning 0xDEADBEEF: miss, oMemAddr=0x40, oRespData=0xDEADBEEF. A second read of 0x40 hits in 2 cycles with no memory request; HitCount=1, MissCount=1.
- With WAYS=2, read 0x40, 0x80, then 0xC0 (all set 0):
  - 0xC0 evicts 0x40 (way 0, pointer 0→1).
  - Reading 0x80 then hits.
  - Reading 0x40 misses.
- Write 0x55 to cached 0x80: memory write seen with oMemWData=0x55, and a later read of 0x80 hits with data 0x55. Write to uncached 0x100: memory write is issued, and a read of 0x100 still misses.
- Hold iMemReqReady low for 5 cycles during a miss: oMemReqValid and oMemAddr stay stable and no response is issued. Assert iFlush mid-miss: the miss completes, then 16 FLUSH cycles run, oFlushDone pulses, and all prior addresses miss.
- Assert iRST_N low during MEM_WAIT: outputs go to 0 at once. After release, a read of the previously cached address misses.
- Preload MissCount to 32'hFFFF_FFFE by forcing the counter, then cause 3 misses: the count holds at 32'hFFFF_FFFF.
